// File: rtl/hvtx_sync.sv
// Decodes an external pixel/line position into registered HS, VS and DE strobes.
// Purely combinational decode followed by one output register stage; no internal counters.
module hvtx_sync #(
    parameter int unsigned FRAME_WIDTH    = 2200,
    parameter int unsigned FRAME_HEIGHT   = 1125,
    parameter int unsigned ACTIVE_WIDTH   = 1920,
    parameter int unsigned ACTIVE_HEIGHT  = 1080,
    parameter int unsigned H_PORCH        = 88,
    parameter int unsigned H_SYNC         = 44,
    parameter int unsigned V_PORCH        = 4,
    parameter int unsigned V_SYNC         = 5,
    parameter bit          HS_ACTIVE_HIGH = 1'b1,
    parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de
);

    // Window edges kept at 32 bits so parameter sums never truncate.
    localparam logic [31:0] HS_START = 32'(ACTIVE_WIDTH + H_PORCH);
    localparam logic [31:0] HS_END   = 32'(ACTIVE_WIDTH + H_PORCH + H_SYNC);
    localparam logic [31:0] VS_START = 32'(ACTIVE_HEIGHT + V_PORCH);
    localparam logic [31:0] VS_END   = 32'(ACTIVE_HEIGHT + V_PORCH + V_SYNC);
    localparam logic [31:0] DE_W     = 32'(ACTIVE_WIDTH);
    localparam logic [31:0] DE_H     = 32'(ACTIVE_HEIGHT);

    if ((ACTIVE_WIDTH + H_PORCH + H_SYNC) > FRAME_WIDTH ||
        (ACTIVE_HEIGHT + V_PORCH + V_SYNC) > FRAME_HEIGHT ||
        H_SYNC == 0 || V_SYNC == 0 || ACTIVE_WIDTH == 0 || ACTIVE_HEIGHT == 0 ||
        FRAME_WIDTH > 4096 || FRAME_HEIGHT > 4096) begin : g_bad_params
        $error("hvtx_sync: inconsistent timing parameters");
    end

    logic [31:0] x_ext;
    logic [31:0] y_ext;
    logic        h_sync_on;
    logic        v_sync_on;
    logic        hs_d, vs_d, de_d;
    logic        hs_q, vs_q, de_q;

    always_comb begin
        x_ext     = {20'd0, i_x};
        y_ext     = {20'd0, i_y};
        h_sync_on = (x_ext >= HS_START) && (x_ext < HS_END);
        v_sync_on = (y_ext >= VS_START) && (y_ext < VS_END);
        hs_d      = h_sync_on ? HS_ACTIVE_HIGH : ~HS_ACTIVE_HIGH;
        vs_d      = v_sync_on ? VS_ACTIVE_HIGH : ~VS_ACTIVE_HIGH;
        de_d      = (x_ext < DE_W) && (y_ext < DE_H);
    end

    // Output register stage; reset drives syncs to their idle level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs_q <= ~HS_ACTIVE_HIGH;
            vs_q <= ~VS_ACTIVE_HIGH;
            de_q <= 1'b0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
        end
    end

    assign o_hs = hs_q;
    assign o_vs = vs_q;
    assign o_de = de_q;

endmodule

// File: tb/tb_hvtx_sync.sv
// Bench for hvtx_sync: default-timing instance plus an active-low HS instance on shared inputs.
module tb_hvtx_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] x;
    logic [11:0] y;
    logic        hs, vs, de;
    logic        hs_n, vs_n, de_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hvtx_sync u_dut (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y),
        .o_hs(hs), .o_vs(vs), .o_de(de)
    );

    hvtx_sync #(.HS_ACTIVE_HIGH(1'b0)) u_dut_n (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y),
        .o_hs(hs_n), .o_vs(vs_n), .o_de(de_n)
    );

    typedef struct {
        logic        rst;
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        de;
        string       nm;
    } vec_t;

    typedef struct {
        logic  hs;
        logic  vs;
        logic  de;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   de_count;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one coordinate on the falling edge, then compare one cycle later.
    task automatic apply(input logic r, input logic [11:0] xi, input logic [11:0] yi,
                         input logic ehs, input logic evs, input logic ede, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        x   = xi;
        y   = yi;
        e.hs = ehs; e.vs = evs; e.de = ede; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk({e.nm, "_hs"},   hs,   e.hs);
            chk({e.nm, "_vs"},   vs,   e.vs);
            chk({e.nm, "_de"},   de,   e.de);
            chk({e.nm, "_hs_n"}, hs_n, ~e.hs);
            chk({e.nm, "_vs_n"}, vs_n, e.vs);
            chk({e.nm, "_de_n"}, de_n, e.de);
            de_count += int'(de);
        end
    endtask

    // Reference timing for the 1080p defaults.
    function automatic logic m_hs(input int xi);
        return (xi >= 2008) && (xi < 2052);
    endfunction
    function automatic logic m_vs(input int yi);
        return (yi >= 1084) && (yi < 1089);
    endfunction
    function automatic logic m_de(input int xi, input int yi);
        return (xi < 1920) && (yi < 1080);
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        x   = '0;
        y   = '0;
        de_count = 0;

        tbl = '{
            '{1'b1, 12'd0,    12'd0,    1'b0, 1'b0, 1'b0, "reset"},
            '{1'b0, 12'd2007, 12'd500,  1'b0, 1'b0, 1'b0, "hs_x2007"},
            '{1'b0, 12'd2008, 12'd500,  1'b1, 1'b0, 1'b0, "hs_x2008"},
            '{1'b0, 12'd2051, 12'd500,  1'b1, 1'b0, 1'b0, "hs_x2051"},
            '{1'b0, 12'd2052, 12'd500,  1'b0, 1'b0, 1'b0, "hs_x2052"},
            '{1'b0, 12'd0,    12'd1083, 1'b0, 1'b0, 1'b0, "vs_y1083"},
            '{1'b0, 12'd0,    12'd1084, 1'b0, 1'b1, 1'b0, "vs_y1084"},
            '{1'b0, 12'd0,    12'd1088, 1'b0, 1'b1, 1'b0, "vs_y1088"},
            '{1'b0, 12'd0,    12'd1089, 1'b0, 1'b0, 1'b0, "vs_y1089"},
            '{1'b0, 12'd1919, 12'd1079, 1'b0, 1'b0, 1'b1, "de_last"},
            '{1'b0, 12'd1920, 12'd1079, 1'b0, 1'b0, 1'b0, "de_xedge"},
            '{1'b0, 12'd1919, 12'd1080, 1'b0, 1'b0, 1'b0, "de_yedge"},
            '{1'b0, 12'd0,    12'd0,    1'b0, 1'b0, 1'b1, "de_origin"},
            '{1'b0, 12'd2030, 12'd1086, 1'b1, 1'b1, 1'b0, "hs_vs_both"},
            '{1'b0, 12'd2010, 12'd1120, 1'b1, 1'b0, 1'b0, "hs_vblank"},
            '{1'b0, 12'd4095, 12'd4095, 1'b0, 1'b0, 1'b0, "beyond_frame"},
            '{1'b0, 12'd2100, 12'd1087, 1'b0, 1'b1, 1'b0, "vs_beyond_x"},
            '{1'b0, 12'd100,  12'd200,  1'b0, 1'b0, 1'b1, "active_mid"},
            '{1'b1, 12'd2010, 12'd500,  1'b0, 1'b0, 1'b0, "rst_in_hs"},
            '{1'b0, 12'd2010, 12'd500,  1'b1, 1'b0, 1'b0, "hs_after_rst"}
        };

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].nm);
        end

        // Reset held three cycles at the origin, then immediate resumption.
        apply(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, "pre_rst");
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, "rst_hold");
        end
        apply(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, "rst_release");

        // Full line inside the active region, and a full vertical-blanking line.
        de_count = 0;
        for (int xi = 0; xi < 2200; xi++) begin
            apply(1'b0, 12'(xi), 12'd500, m_hs(xi), m_vs(500), m_de(xi, 500), "line500");
        end
        chk_int("de_count_line500", de_count, 1920);

        de_count = 0;
        for (int xi = 0; xi < 2200; xi++) begin
            apply(1'b0, 12'(xi), 12'd1086, m_hs(xi), m_vs(1086), m_de(xi, 1086), "line1086");
        end
        chk_int("de_count_line1086", de_count, 0);

        // Column sweep at x=0 across all lines of the frame.
        de_count = 0;
        for (int yi = 0; yi < 1125; yi++) begin
            apply(1'b0, 12'd0, 12'(yi), m_hs(0), m_vs(yi), m_de(0, yi), "col0");
        end
        chk_int("de_count_col0", de_count, 1080);

        // Random coordinates over the full 12-bit range.
        for (int i = 0; i < 300; i++) begin
            int rx, ry;
            rx = int'($urandom_range(4095, 0));
            ry = int'($urandom_range(4095, 0));
            apply(1'b0, 12'(rx), 12'(ry), m_hs(rx), m_vs(ry), m_de(rx, ry), "rand");
        end

        chk_int("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hvtx_sync.md
HVTX_SYNC -- requirements
Module: hvtx_sync

Interface
REQ-001 The block SHALL have parameter FRAME_WIDTH, default 2200, meaning total pixels per line including blanking.
REQ-002 The block SHALL have parameter FRAME_HEIGHT, default 1125, meaning total lines per frame including blanking.
REQ-003 The block SHALL have parameter ACTIVE_WIDTH, default 1920, meaning visible pixels per line.
REQ-004 The block SHALL have parameter ACTIVE_HEIGHT, default 1080, meaning visible lines per frame.
REQ-005 The block SHALL have parameter H_PORCH, default 88, meaning horizontal front porch in pixels.
REQ-006 The block SHALL have parameter H_SYNC, default 44, meaning horizontal sync pulse width in pixels.
REQ-007 The block SHALL have parameter V_PORCH, default 4, meaning vertical front porch in lines.
REQ-008 The block SHALL have parameter V_SYNC, default 5, meaning vertical sync pulse width in lines.
REQ-009 The block SHALL have parameter HS_ACTIVE_HIGH, default 1, meaning o_hs polarity (1 = high during sync).
REQ-010 The block SHALL have parameter VS_ACTIVE_HIGH, default 1, meaning o_vs polarity (1 = high during sync).
REQ-011 The block SHALL have port i_clk, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-012 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-013 The block SHALL have port i_x, input, 12 bits: current pixel column.
REQ-014 The block SHALL have port i_y, input, 12 bits: current line.
REQ-015 The block SHALL have port o_hs, output, 1 bit: horizontal sync, registered.
REQ-016 The block SHALL have port o_vs, output, 1 bit: vertical sync, registered.
REQ-017 The block SHALL have port o_de, output, 1 bit: data enable (active video), registered.

Function
REQ-018 All outputs SHALL be registered, with exactly 1 clock of latency from i_x/i_y to o_hs/o_vs/o_de.
REQ-019 o_de SHALL be 1 iff i_x < ACTIVE_WIDTH and i_y < ACTIVE_HEIGHT.
REQ-020 Horizontal sync SHALL be asserted iff ACTIVE_WIDTH+H_PORCH <= i_x < ACTIVE_WIDTH+H_PORCH+H_SYNC; with defaults this is x 2008..2051.
REQ-021 Vertical sync SHALL be asserted iff ACTIVE_HEIGHT+V_PORCH <= i_y < ACTIVE_HEIGHT+V_PORCH+V_SYNC; with defaults this is y 1084..1088.
REQ-022 Vertical sync SHALL depend on i_y only, and SHALL NOT be qualified by i_x.
REQ-023 Horizontal sync SHALL depend on i_x only, and SHALL be active on every line, blanking lines included.
REQ-024 When sync is asserted, o_hs SHALL equal HS_ACTIVE_HIGH; otherwise it SHALL equal its complement.
REQ-025 When sync is asserted, o_vs SHALL equal VS_ACTIVE_HIGH; otherwise it SHALL equal its complement.
REQ-026 Comparisons SHALL be unsigned, performed at 12 bits or wider; parameter sums SHALL be evaluated at elaboration without truncation.
REQ-027 Coordinates at or beyond FRAME_WIDTH or FRAME_HEIGHT SHALL be treated as blanking: o_de=0, and sync follows REQ-020/021 literally.
REQ-028 Elaboration SHALL fail with an error if ACTIVE_WIDTH+H_PORCH+H_SYNC > FRAME_WIDTH, or ACTIVE_HEIGHT+V_PORCH+V_SYNC > FRAME_HEIGHT, or any of H_SYNC, V_SYNC, ACTIVE_WIDTH, ACTIVE_HEIGHT is 0, or FRAME_WIDTH or FRAME_HEIGHT > 4096.
REQ-029 The block SHALL hold no state other than the three output registers; no internal counters.

Reset
REQ-030 While i_rst=1 at a clock edge, next cycle SHALL give o_de=0, o_hs=deasserted level (0 for defaults), o_vs=deasserted level (0 for defaults).
REQ-031 On the first edge with i_rst=0, outputs SHALL resume per REQ-019..025; reset mid-frame SHALL need no resynchronisation.

Verification
REQ-032 With defaults, sweep x 0..2199, y 0..1124 -> o_de high exactly 1920x1080 = 2,073,600 cycles per frame, one cycle after the coordinates.
REQ-033 With defaults, y=500, x=2007/2008/2051/2052 -> o_hs next cycle 0/1/1/0; o_vs=0 and o_de=0 throughout.
REQ-034 With defaults, x=0, y=1083/1084/1088/1089 -> o_vs next cycle 0/1/1/0; o_de=0.
REQ-035 With defaults, x=1919,y=1079 -> o_de=1; x=1920,y=1079 -> o_de=0; x=1919,y=1080 -> o_de=0.
REQ-036 With HS_ACTIVE_HIGH=0, x=2010 -> o_hs=0; with HS_ACTIVE_HIGH=0, x=100 -> o_hs=1; assert i_rst at x=2010 -> o_hs=1 (idle level), o_de=0.
REQ-037 With x=0,y=0, assert i_rst for 3 cycles then release -> outputs at reset levels during reset; o_de=1 one cycle after release.
